// File: rtl/tl_probe_initiator.sv
// tl_probe_initiator
//
// Manager-side TileLink probe engine. Takes one probe job (line address,
// cap permission, sharer mask). It sends a B-channel Probe to each client in
// the mask, lowest index first, and collects the C-channel ProbeAck and
// ProbeAckData beats. When every expected ack has completed, it returns one
// completion to the MSHR.
//
// Ports
//   clock, reset                      clock, synchronous active-high reset
//   req_valid/ready/addr/param/sharers  probe job input
//   b_valid/ready/opcode/param/address/source  Probe issue (B channel)
//   c_valid/ready/opcode/source/address/last    ack collection (C channel)
//   resp_valid/ready/addr/dirty/error           job completion
//   busy                              engine is not idle
//
// All outputs come from state or registers. No input reaches an output
// within the same cycle.

module tl_probe_initiator #(
    parameter int N_CLIENTS = 2,
    parameter int ADDR_W    = 32,
    parameter int SRC_W     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [1:0]           req_param,
    input  logic [N_CLIENTS-1:0] req_sharers,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [2:0]           b_opcode,
    output logic [1:0]           b_param,
    output logic [ADDR_W-1:0]    b_address,
    output logic [SRC_W-1:0]     b_source,
    input  logic                 c_valid,
    output logic                 c_ready,
    input  logic [2:0]           c_opcode,
    input  logic [SRC_W-1:0]     c_source,
    input  logic [ADDR_W-1:0]    c_address,
    input  logic                 c_last,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ADDR_W-1:0]    resp_addr,
    output logic                 resp_dirty,
    output logic                 resp_error,
    output logic                 busy
);

    // state   | meaning
    // s_idle  | waiting for a probe job, req_ready=1
    // s_probe | issuing Probes from to_probe, collecting acks
    // s_wait  | all Probes sent, collecting the remaining acks
    // s_resp  | completion presented until resp_ready
    typedef enum logic [1:0] {
        s_idle  = 2'd0,
        s_probe = 2'd1,
        s_wait  = 2'd2,
        s_resp  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]    addr_q;
    logic [1:0]           param_q;
    logic [N_CLIENTS-1:0] to_probe_q;
    logic [N_CLIENTS-1:0] pending_q;
    logic                 dirty_q;
    logic                 error_q;

    logic                 req_fire;
    logic                 b_fire;
    logic                 c_fire;
    logic                 c_expected;
    logic [N_CLIENTS-1:0] src_onehot;
    logic [N_CLIENTS-1:0] probe_onehot;
    logic [N_CLIENTS-1:0] ack_clear;
    logic [N_CLIENTS-1:0] to_probe_next;
    logic [N_CLIENTS-1:0] pending_next;
    logic [SRC_W-1:0]     probe_idx;

    assign req_fire = req_valid && req_ready;
    assign b_fire   = b_valid && b_ready;
    assign c_fire   = c_valid && c_ready;

    // Isolate the lowest set bit of to_probe. This is the client targeted this cycle.
    assign probe_onehot = to_probe_q & (~to_probe_q + N_CLIENTS'(1));

    always_comb begin
        probe_idx = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (to_probe_q[i]) probe_idx = SRC_W'(i);
        end
    end

    // A source index outside the client range matches no bit, so that beat
    // counts as unexpected.
    always_comb begin
        src_onehot = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            src_onehot[i] = (c_source == SRC_W'(i));
        end
    end

    // An ack is expected only from a client whose probe fired in an earlier
    // cycle. That client still has pending set and to_probe already cleared.
    assign c_expected = |(src_onehot & pending_q & ~to_probe_q)
                        && (c_address == addr_q)
                        && (c_opcode == 3'd4 || c_opcode == 3'd5);

    assign ack_clear     = (c_fire && c_expected && c_last) ? src_onehot : '0;
    assign pending_next  = pending_q & ~ack_clear;
    assign to_probe_next = b_fire ? (to_probe_q & ~probe_onehot) : to_probe_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= s_idle;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            s_idle: begin
                // An empty mask goes through s_wait for one cycle. Its
                // completion then appears two cycles after acceptance.
                if (req_fire) state_next = (req_sharers == '0) ? s_wait : s_probe;
            end
            s_probe: begin
                if (b_fire && to_probe_next == '0)
                    state_next = (pending_next == '0) ? s_resp : s_wait;
            end
            s_wait: begin
                if (pending_next == '0) state_next = s_resp;
            end
            s_resp: begin
                if (resp_ready) state_next = s_idle;
            end
            default: state_next = s_idle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req_ready  = (state == s_idle);
        b_valid    = (state == s_probe);
        c_ready    = (state == s_probe) || (state == s_wait);
        resp_valid = (state == s_resp);
        busy       = (state != s_idle);
    end

    // Job datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            param_q    <= '0;
            to_probe_q <= '0;
            pending_q  <= '0;
            dirty_q    <= 1'b0;
            error_q    <= 1'b0;
        end else if (req_fire) begin
            addr_q     <= req_addr;
            param_q    <= req_param;
            to_probe_q <= req_sharers;
            pending_q  <= req_sharers;
            dirty_q    <= 1'b0;
            error_q    <= 1'b0;
        end else if (state == s_probe || state == s_wait) begin
            to_probe_q <= to_probe_next;
            pending_q  <= pending_next;
            if (c_fire && c_expected && c_opcode == 3'd5) dirty_q <= 1'b1;
            if (c_fire && !c_expected)                    error_q <= 1'b1;
        end
    end

    assign b_opcode   = 3'd6;
    assign b_param    = param_q;
    assign b_address  = addr_q;
    assign b_source   = probe_idx;
    assign resp_addr  = addr_q;
    assign resp_dirty = dirty_q;
    assign resp_error = error_q;

endmodule

// File: tb/tb_tl_probe_initiator.sv
module tb_tl_probe_initiator;

    localparam int N = 2;
    localparam int A = 32;
    localparam int S = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [A-1:0]  req_addr;
    logic [1:0]    req_param;
    logic [N-1:0]  req_sharers;
    logic          b_valid;
    logic          b_ready;
    logic [2:0]    b_opcode;
    logic [1:0]    b_param;
    logic [A-1:0]  b_address;
    logic [S-1:0]  b_source;
    logic          c_valid;
    logic          c_ready;
    logic [2:0]    c_opcode;
    logic [S-1:0]  c_source;
    logic [A-1:0]  c_address;
    logic          c_last;
    logic          resp_valid;
    logic          resp_ready;
    logic [A-1:0]  resp_addr;
    logic          resp_dirty;
    logic          resp_error;
    logic          busy;

    tl_probe_initiator #(.N_CLIENTS(N), .ADDR_W(A), .SRC_W(S)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_param(req_param), .req_sharers(req_sharers),
        .b_valid(b_valid), .b_ready(b_ready), .b_opcode(b_opcode),
        .b_param(b_param), .b_address(b_address), .b_source(b_source),
        .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode),
        .c_source(c_source), .c_address(c_address), .c_last(c_last),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_addr(resp_addr),
        .resp_dirty(resp_dirty), .resp_error(resp_error), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [A-1:0] addr;
        logic         dirty;
        logic         error;
    } resp_t;

    resp_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [A-1:0] addr, input logic [1:0] param,
                             input logic [N-1:0] sharers, input logic dirty,
                             input logic error);
        resp_t e;
        chk("req_ready_before_job", 64'(req_ready), 64'(1));
        req_valid   = 1'b1;
        req_addr    = addr;
        req_param   = param;
        req_sharers = sharers;
        e.addr  = addr;
        e.dirty = dirty;
        e.error = error;
        exp_q.push_back(e);
        tick();
        req_valid   = 1'b0;
        req_addr    = 32'hDEAD_BEEF;
        req_sharers = '1;
    endtask

    task automatic send_c(input logic [S-1:0] src, input logic [2:0] op,
                          input logic [A-1:0] addr, input logic last);
        c_valid   = 1'b1;
        c_source  = src;
        c_opcode  = op;
        c_address = addr;
        c_last    = last;
        chk("c_ready", 64'(c_ready), 64'(1));
        tick();
        c_valid = 1'b0;
    endtask

    task automatic check_resp(input string tag);
        resp_t e;
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(1));
        chk({tag, "_sb_depth"}, 64'(exp_q.size()), 64'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_resp_addr"}, 64'(resp_addr), 64'(e.addr));
            chk({tag, "_resp_dirty"}, 64'(resp_dirty), 64'(e.dirty));
            chk({tag, "_resp_error"}, 64'(resp_error), 64'(e.error));
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_idle_resp_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, "_idle_req_ready"}, 64'(req_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_param = '0; req_sharers = '0;
        b_ready = 1'b1; c_valid = 1'b0; c_opcode = '0; c_source = '0; c_address = '0;
        c_last = 1'b0; resp_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_b_valid", 64'(b_valid), 64'(0));
        chk("rst_c_ready", 64'(c_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_dirty", 64'(resp_dirty), 64'(0));
        chk("rst_error", 64'(resp_error), 64'(0));
        chk("rst_b_source", 64'(b_source), 64'(0));
        chk("rst_b_address", 64'(b_address), 64'(0));
        chk("rst_b_param", 64'(b_param), 64'(0));
        chk("rst_resp_addr", 64'(resp_addr), 64'(0));

        // Job 1: two sharers, acks in reverse order
        start_job(32'h8000_0040, 2'd2, 2'b11, 1'b0, 1'b0);
        chk("j1_b_valid0", 64'(b_valid), 64'(1));
        chk("j1_b_source0", 64'(b_source), 64'(0));
        chk("j1_b_opcode", 64'(b_opcode), 64'(6));
        chk("j1_b_param", 64'(b_param), 64'(2));
        chk("j1_b_address", 64'(b_address), 64'(32'h8000_0040));
        tick();
        chk("j1_b_valid1", 64'(b_valid), 64'(1));
        chk("j1_b_source1", 64'(b_source), 64'(1));
        tick();
        chk("j1_b_done", 64'(b_valid), 64'(0));
        chk("j1_busy", 64'(busy), 64'(1));
        send_c(4'd1, 3'd4, 32'h8000_0040, 1'b1);
        chk("j1_no_resp_early", 64'(resp_valid), 64'(0));
        send_c(4'd0, 3'd4, 32'h8000_0040, 1'b1);
        check_resp("j1");

        // Job 2: one sharer, 4-beat ProbeAckData
        start_job(32'h1000_0080, 2'd1, 2'b01, 1'b1, 1'b0);
        chk("j2_b_source", 64'(b_source), 64'(0));
        tick();
        for (int beat = 0; beat < 4; beat++) begin
            chk("j2_no_resp_before_last", 64'(resp_valid), 64'(0));
            send_c(4'd0, 3'd5, 32'h1000_0080, beat == 3);
        end
        check_resp("j2");

        // Job 3: empty mask
        start_job(32'h2000_0000, 2'd0, 2'b00, 1'b0, 1'b0);
        chk("j3_b_valid_t1", 64'(b_valid), 64'(0));
        chk("j3_resp_t1", 64'(resp_valid), 64'(0));
        chk("j3_busy_t1", 64'(busy), 64'(1));
        tick();
        chk("j3_b_valid_t2", 64'(b_valid), 64'(0));
        check_resp("j3");

        // Job 4: B channel back-pressure
        b_ready = 1'b0;
        start_job(32'h3000_00C0, 2'd1, 2'b10, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("j4_hold_b_valid", 64'(b_valid), 64'(1));
            chk("j4_hold_b_source", 64'(b_source), 64'(1));
            chk("j4_hold_b_address", 64'(b_address), 64'(32'h3000_00C0));
            chk("j4_hold_b_param", 64'(b_param), 64'(1));
            tick();
        end
        b_ready = 1'b1;
        chk("j4_b_valid_release", 64'(b_valid), 64'(1));
        tick();
        chk("j4_b_fired", 64'(b_valid), 64'(0));
        send_c(4'd1, 3'd4, 32'h3000_00C0, 1'b1);
        check_resp("j4");

        // Job 5: ack in the same cycle as a probe fire, then a stray ack
        start_job(32'h4000_0100, 2'd2, 2'b11, 1'b0, 1'b1);
        chk("j5_b_source0", 64'(b_source), 64'(0));
        tick();
        chk("j5_b_source1", 64'(b_source), 64'(1));
        send_c(4'd0, 3'd4, 32'h4000_0100, 1'b1);
        chk("j5_in_wait_b_valid", 64'(b_valid), 64'(0));
        chk("j5_in_wait_busy", 64'(busy), 64'(1));
        chk("j5_no_resp", 64'(resp_valid), 64'(0));
        chk("j5_no_error_yet", 64'(resp_error), 64'(0));
        send_c(4'd0, 3'd4, 32'h4000_0140, 1'b1);
        chk("j5_error_set", 64'(resp_error), 64'(1));
        chk("j5_still_waiting", 64'(resp_valid), 64'(0));
        chk("j5_still_busy", 64'(busy), 64'(1));
        send_c(4'd1, 3'd4, 32'h4000_0100, 1'b1);
        check_resp("j5");

        // Job 6: reset while waiting, then a fresh job
        start_job(32'h5000_0000, 2'd0, 2'b01, 1'b0, 1'b0);
        tick();
        chk("j6_waiting", 64'(busy), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk("j6_rst_busy", 64'(busy), 64'(0));
        chk("j6_rst_req_ready", 64'(req_ready), 64'(1));
        chk("j6_rst_resp_valid", 64'(resp_valid), 64'(0));
        start_job(32'h6000_0040, 2'd1, 2'b01, 1'b1, 1'b0);
        chk("j7_b_source", 64'(b_source), 64'(0));
        tick();
        send_c(4'd0, 3'd5, 32'h6000_0040, 1'b1);
        check_resp("j7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
